// File: rtl/xbus_cycle_ctl_pkg.sv
// xbus_cycle_ctl_pkg: shared state encodings and defaults for the bus cycle controller
package xbus_cycle_ctl_pkg;
   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_START = 2'd1;
   localparam logic [1:0] ST_WAIT  = 2'd2;
   localparam logic [1:0] ST_FIN   = 2'd3;
   localparam int TIMEOUT_DEF = 200;
endpackage

// File: rtl/xbus_cycle_ctl_sync_chain.sv
// xbus_cycle_ctl_sync_chain: multi-flop synchroniser for one asynchronous level
module xbus_cycle_ctl_sync_chain #(
   parameter int STAGES = 2
) (
   input  logic clk,
   input  logic reset_n,
   input  logic d,
   output logic q
);
   logic [STAGES-1:0] sr_q;
   // shift the async level through the chain; last stage is the clean copy
   always_ff @(posedge clk) begin
      if (!reset_n) sr_q <= '0;
      else sr_q <= {sr_q[STAGES-2:0], d};
   end
   assign q = sr_q[STAGES-1];
endmodule

// File: rtl/xbus_cycle_ctl.sv
// xbus_cycle_ctl: runs one bus cycle per synchronised request edge, ending in done or NXM timeout
module xbus_cycle_ctl
   import xbus_cycle_ctl_pkg::*;
#(
   parameter int SYNC_STAGES = 2,
   parameter int TW          = 8,
   parameter int TIMEOUT     = TIMEOUT_DEF
) (
   input  logic clk,
   input  logic reset_n,
   input  logic req_async,
   input  logic wr_in,
   input  logic ack_async,
   input  logic nxm_clr,
   output logic busy,
   output logic start,
   output logic wr,
   output logic done,
   output logic nxm,
   output logic nxm_flag
);
   logic req_s, ack_s, req_d_q, req_rise, term;
   logic [SYNC_STAGES:0] arm_q;
   logic [1:0] state_q, state_d;
   logic [TW-1:0] cnt_q, cnt_d;
   logic ok_q, ok_d;
   logic busy_q, start_q, wr_q, done_q, nxm_q, flag_q;

   xbus_cycle_ctl_sync_chain #(.STAGES(SYNC_STAGES)) u_req_sync (
      .clk(clk), .reset_n(reset_n), .d(req_async), .q(req_s)
   );
   xbus_cycle_ctl_sync_chain #(.STAGES(SYNC_STAGES)) u_ack_sync (
      .clk(clk), .reset_n(reset_n), .d(ack_async), .q(ack_s)
   );

   // arm_q masks the artificial 0->1 seen while the chain refills after reset,
   // so a request level present during reset is not mistaken for an edge
   assign req_rise = req_s & ~req_d_q & arm_q[SYNC_STAGES];
   assign term     = cnt_q == TW'(TIMEOUT - 1);

   // next-state, counter and outcome selection; ack has priority over terminal count
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      ok_d    = ok_q;
      case (state_q)
         ST_IDLE:  state_d = req_rise ? ST_START : ST_IDLE;
         ST_START: begin
            state_d = ST_WAIT;
            cnt_d   = '0;
         end
         ST_WAIT: begin
            cnt_d   = cnt_q + 1'b1;
            state_d = (ack_s || term) ? ST_FIN : ST_WAIT;
            ok_d    = (ack_s || term) ? ack_s : ok_q;
         end
         default:  state_d = ST_IDLE;
      endcase
   end

   // state, edge history and registered outputs decoded from the next state
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         ok_q    <= 1'b0;
         req_d_q <= 1'b0;
         arm_q   <= '0;
         busy_q  <= 1'b0;
         start_q <= 1'b0;
         wr_q    <= 1'b0;
         done_q  <= 1'b0;
         nxm_q   <= 1'b0;
         flag_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         ok_q    <= ok_d;
         req_d_q <= req_s;
         arm_q   <= {arm_q[SYNC_STAGES-1:0], 1'b1};
         busy_q  <= state_d == ST_START || state_d == ST_WAIT;
         start_q <= state_d == ST_START;
         wr_q    <= state_q == ST_START ? wr_in : wr_q;
         done_q  <= state_d == ST_FIN && ok_d;
         nxm_q   <= state_d == ST_FIN && !ok_d;
         flag_q  <= (state_q == ST_FIN && !ok_q) ? 1'b1 : nxm_clr ? 1'b0 : flag_q;
      end
   end

   assign busy     = busy_q;
   assign start    = start_q;
   assign wr       = wr_q;
   assign done     = done_q;
   assign nxm      = nxm_q;
   assign nxm_flag = flag_q;
endmodule
